// File: rtl/cache_axi_bridge_n.sv
// cache_axi_bridge_n: NUM_RD cache read clients + one line-write port onto
// a single AXI3 master. Reads are tagged arid=client and routed back by rid.
// Ports: aclk/aresetn; rd_req/rd_type/rd_addr/rd_rdy per client;
//        ret_valid/ret_last/ret_data; wr_req/wr_type/wr_addr/wr_wstrb/
//        wr_data/wr_rdy; AXI3 AR/R/AW/W/B master channels (4-bit ids).
// Option: CACHE_BRIDGE_RR_ARB_EN selects round-robin read arbitration,
//         otherwise lowest-index eligible client wins.
module cache_axi_bridge_n #(
    parameter int NUM_RD     = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_RD-1:0]       rd_req,
    input  logic [3*NUM_RD-1:0]     rd_type,
    input  logic [32*NUM_RD-1:0]    rd_addr,
    output logic [NUM_RD-1:0]       rd_rdy,
    output logic [NUM_RD-1:0]       ret_valid,
    output logic                    ret_last,
    output logic [31:0]             ret_data,
    input  logic                    wr_req,
    input  logic [2:0]              wr_type,
    input  logic [31:0]             wr_addr,
    input  logic [3:0]              wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                    wr_rdy,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int LINE_OFF = $clog2(LINE_WORDS) + 2;

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wst_e;

    wst_e                    wst_q, wst_d;
    logic                    live_q;
    logic                    ar_full_q;
    logic [3:0]              ar_id_q, ar_len_q;
    logic [31:0]             ar_addr_q;
    logic [2:0]              ar_size_q;
    logic [NUM_RD-1:0]       busy_q, busy_d;
    logic [31:0]             wa_q;
    logic                    wline_q;
    logic [2:0]              wsize_q;
    logic [3:0]              wstrb_q, beat_q;
    logic [32*LINE_WORDS-1:0] wdata_q;
    logic                    aw_done_q, w_done_q;

    logic [NUM_RD-1:0]       hazard, elig;
    logic [31-LINE_OFF:0]    rline;
    logic                    gnt_v, accept, wr_acc, wr_pend;
    logic [3:0]              gnt;
    logic [2:0]              sel_type;
    logic [31:0]             sel_addr;
    logic                    unused_ok;

    assign unused_ok = &{1'b0, rresp, bresp, bid};

    assign rready  = 1'b1;
    assign bready  = 1'b1;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'h0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'h0;
    assign awid    = 4'(NUM_RD);
    assign wid     = 4'(NUM_RD);

    assign wr_pend = (wst_q != W_IDLE);
    assign wr_rdy  = live_q && (wst_q == W_IDLE);
    assign wr_acc  = wr_req && wr_rdy;

    // A read to the line being written (or being accepted for write this
    // cycle) must wait until the B response retires the write.
    always_comb begin
        hazard = '0;
        rline  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rline = rd_addr[i*32+LINE_OFF +: 32-LINE_OFF];
            hazard[i] = (wr_pend && rline == wa_q[31:LINE_OFF])
                     || (wr_acc && rline == wr_addr[31:LINE_OFF]);
        end
    end

    assign elig = rd_req & ~busy_q & ~hazard;

`ifdef CACHE_BRIDGE_RR_ARB_EN
    logic [3:0] rr_ptr_q;
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        // Scan from the farthest offset down so the nearest to ptr wins.
        for (int k = NUM_RD-1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NUM_RD;
            if (elig[idx]) begin
                gnt_v = 1'b1;
                gnt   = 4'(idx);
            end
        end
    end
`else
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        for (int k = NUM_RD-1; k >= 0; k--) begin
            if (elig[k]) begin
                gnt_v = 1'b1;
                gnt   = 4'(k);
            end
        end
    end
`endif

    always_comb begin
        rd_rdy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_rdy[i] = live_q && !ar_full_q && gnt_v && (gnt == 4'(i));
        end
    end

    assign accept   = |(rd_req & rd_rdy);
    assign sel_type = rd_type[int'(gnt)*3 +: 3];
    assign sel_addr = rd_addr[int'(gnt)*32 +: 32];

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rvalid && rlast && rid == 4'(i)) busy_d[i] = 1'b0;
            if (accept && gnt == 4'(i)) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live_q    <= 1'b0;
            ar_full_q <= 1'b0;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
            busy_q    <= '0;
        end else begin
            live_q <= 1'b1;
            busy_q <= busy_d;
            if (accept) begin
                ar_full_q <= 1'b1;
                ar_id_q   <= gnt;
                if (sel_type[2]) begin
                    ar_addr_q <= {sel_addr[31:LINE_OFF], {LINE_OFF{1'b0}}};
                    ar_len_q  <= 4'(LINE_WORDS-1);
                    ar_size_q <= 3'd2;
                end else begin
                    ar_addr_q <= sel_addr;
                    ar_len_q  <= 4'd0;
                    ar_size_q <= {1'b0, sel_type[1:0]};
                end
            end else if (arready) begin
                ar_full_q <= 1'b0;
            end
        end
    end

`ifdef CACHE_BRIDGE_RR_ARB_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= (int'(gnt) + 1 == NUM_RD) ? 4'd0 : gnt + 4'd1;
        end
    end
`endif

    assign arvalid = ar_full_q;
    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arlen   = ar_len_q;
    assign arsize  = ar_size_q;

    always_comb begin
        ret_valid = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ret_valid[i] = rvalid && (rid == 4'(i));
        end
    end
    assign ret_last = rlast;
    assign ret_data = rdata;

    assign awvalid = (wst_q == W_SEND) && !aw_done_q;
    assign wvalid  = (wst_q == W_SEND) && !w_done_q;
    assign awaddr  = wa_q;
    assign awlen   = wline_q ? 4'(LINE_WORDS-1) : 4'd0;
    assign awsize  = wline_q ? 3'd2 : wsize_q;
    assign wdata   = wdata_q[int'(beat_q)*32 +: 32];
    assign wstrb   = wline_q ? 4'hF : wstrb_q;
    assign wlast   = wline_q ? (beat_q == 4'(LINE_WORDS-1)) : 1'b1;

    always_comb begin
        wst_d = wst_q;
        unique case (wst_q)
            W_IDLE: if (wr_acc) wst_d = W_SEND;
            W_SEND: begin
                if ((aw_done_q || awready) &&
                    (w_done_q || (wready && wlast))) wst_d = W_RESP;
            end
            W_RESP: if (bvalid) wst_d = W_IDLE;
            default: wst_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) wst_q <= W_IDLE;
        else          wst_q <= wst_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wa_q      <= '0;
            wline_q   <= 1'b0;
            wsize_q   <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            beat_q    <= '0;
        end else if (wr_acc) begin
            wa_q      <= wr_type[2] ?
                         {wr_addr[31:LINE_OFF], {LINE_OFF{1'b0}}} : wr_addr;
            wline_q   <= wr_type[2];
            wsize_q   <= {1'b0, wr_type[1:0]};
            wstrb_q   <= wr_wstrb;
            wdata_q   <= wr_data;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            beat_q    <= '0;
        end else if (wst_q == W_SEND) begin
            if (awvalid && awready) aw_done_q <= 1'b1;
            if (wvalid && wready) begin
                if (wlast) w_done_q <= 1'b1;
                else       beat_q   <= beat_q + 4'd1;
            end
        end
    end
endmodule
